// File: rtl/pla_seq_eval_if.sv
// rtl/pla_seq_eval_if.sv - config, input and result handshake bundle for pla_seq_eval
interface pla_seq_eval_if #(
    parameter int N_IN    = 30,
    parameter int N_OUT   = 63,
    parameter int N_TERMS = 64
);
    localparam int HW = $clog2(N_TERMS + 1);
    localparam int AW = $clog2(N_TERMS);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [N_IN-1:0]  cfg_care;
    logic [N_IN-1:0]  cfg_val;
    logic [N_OUT-1:0] cfg_omask;
    logic             cfg_clr;
    logic             cfg_ready;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_x;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_z;
    logic [HW-1:0]    out_hits;

    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask, cfg_clr,
        output in_valid, in_x, out_ready,
        input  cfg_ready, in_ready, out_valid, out_z, out_hits
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask, cfg_clr,
        input  in_valid, in_x, out_ready,
        output cfg_ready, in_ready, out_valid, out_z, out_hits
    );
endinterface

// File: rtl/pla_seq_eval.sv
// rtl/pla_seq_eval.sv - runtime-loadable, time-multiplexed sum-of-products evaluator
module pla_seq_eval #(
    parameter int N_IN            = 30,
    parameter int N_OUT           = 63,
    parameter int N_TERMS         = 64,
    parameter int TERMS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    pla_seq_eval_if.slave bus
);
    localparam int HW   = $clog2(N_TERMS + 1);
    localparam int AW   = $clog2(N_TERMS);
    localparam int LAST = N_TERMS - TERMS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t state, state_nxt;

    logic [N_TERMS-1:0] tvalid;
    logic [N_IN-1:0]    care_mem  [N_TERMS];
    logic [N_IN-1:0]    val_mem   [N_TERMS];
    logic [N_OUT-1:0]   omask_mem [N_TERMS];

    logic [N_IN-1:0]    x_q;
    logic [N_OUT-1:0]   acc;
    logic [HW-1:0]      hits;
    logic [AW-1:0]      idx;
    logic [N_OUT-1:0]   out_z_q;
    logic [HW-1:0]      out_hits_q;
    logic               out_valid_q;

    logic                       idle;
    logic                       last;
    logic [TERMS_PER_CYCLE-1:0] hit_vec;
    logic [AW-1:0]              tid     [TERMS_PER_CYCLE];
    logic [N_OUT-1:0]           term_om [TERMS_PER_CYCLE];
    logic [N_OUT-1:0]           grp_or;
    logic [HW-1:0]              grp_cnt;

    assign idle = (state == IDLE);
    assign last = (idx == AW'(LAST));

    // Table writes only land in IDLE, so the table is frozen while a vector is being evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= '0;
        end else if (idle) begin
            if (bus.cfg_clr) tvalid <= '0;
            if (bus.cfg_we)  tvalid[bus.cfg_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (idle && bus.cfg_we) begin
            care_mem[bus.cfg_addr]  <= bus.cfg_care;
            val_mem[bus.cfg_addr]   <= bus.cfg_val;
            omask_mem[bus.cfg_addr] <= bus.cfg_omask;
        end
    end

    for (genvar g = 0; g < TERMS_PER_CYCLE; g++) begin : g_match
        assign tid[g]     = idx + AW'(g);
        assign hit_vec[g] = tvalid[tid[g]] && (((x_q ^ val_mem[tid[g]]) & care_mem[tid[g]]) == '0);
        assign term_om[g] = hit_vec[g] ? omask_mem[tid[g]] : '0;
    end

    always_comb begin
        grp_or  = '0;
        grp_cnt = '0;
        for (int k = 0; k < TERMS_PER_CYCLE; k++) begin
            grp_or  = grp_or | term_om[k];
            grp_cnt = grp_cnt + HW'(hit_vec[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = EVAL;
            EVAL:    if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            acc         <= '0;
            hits        <= '0;
            idx         <= '0;
            out_z_q     <= '0;
            out_hits_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q  <= bus.in_x;
                        acc  <= '0;
                        hits <= '0;
                        idx  <= '0;
                    end
                end
                EVAL: begin
                    // The final group goes straight into the result registers; idx never wraps.
                    if (last) begin
                        out_z_q     <= acc | grp_or;
                        out_hits_q  <= hits + grp_cnt;
                        out_valid_q <= 1'b1;
                    end else begin
                        acc  <= acc | grp_or;
                        hits <= hits + grp_cnt;
                        idx  <= idx + AW'(TERMS_PER_CYCLE);
                    end
                end
                DONE: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.cfg_ready = idle;
    assign bus.in_ready  = idle;
    assign bus.out_valid = out_valid_q;
    assign bus.out_z     = out_z_q;
    assign bus.out_hits  = out_hits_q;
endmodule

// File: tb/tb_pla_seq_eval.sv
// tb/tb_pla_seq_eval.sv - directed checks of pla_seq_eval at 1 and 4 terms per cycle
module tb_pla_seq_eval;
    localparam logic [62:0] B62 = 63'h4000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cfg_we = 1'b0, cfg_clr = 1'b0, in_valid = 1'b0, rdy1 = 1'b0, rdy4 = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [29:0] cfg_care = '0, cfg_val = '0, in_x = '0;
    logic [62:0] cfg_omask = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    pla_seq_eval_if #(.N_IN(30), .N_OUT(63), .N_TERMS(64)) b1 ();
    pla_seq_eval_if #(.N_IN(30), .N_OUT(63), .N_TERMS(64)) b4 ();

    assign b1.cfg_we = cfg_we;       assign b4.cfg_we = cfg_we;
    assign b1.cfg_clr = cfg_clr;     assign b4.cfg_clr = cfg_clr;
    assign b1.cfg_addr = cfg_addr;   assign b4.cfg_addr = cfg_addr;
    assign b1.cfg_care = cfg_care;   assign b4.cfg_care = cfg_care;
    assign b1.cfg_val = cfg_val;     assign b4.cfg_val = cfg_val;
    assign b1.cfg_omask = cfg_omask; assign b4.cfg_omask = cfg_omask;
    assign b1.in_valid = in_valid;   assign b4.in_valid = in_valid;
    assign b1.in_x = in_x;           assign b4.in_x = in_x;
    assign b1.out_ready = rdy1;      assign b4.out_ready = rdy4;

    pla_seq_eval #(.N_IN(30), .N_OUT(63), .N_TERMS(64), .TERMS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));
    pla_seq_eval #(.N_IN(30), .N_OUT(63), .N_TERMS(64), .TERMS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4));

    typedef struct {
        int          setup;
        logic [29:0] x;
        logic [62:0] z;
        logic [6:0]  h;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [29:0] c, input logic [29:0] v,
                             input logic [62:0] om, input logic clr);
        cfg_we = 1'b1; cfg_clr = clr; cfg_addr = a; cfg_care = c; cfg_val = v; cfg_omask = om;
        step();
        cfg_we = 1'b0; cfg_clr = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [29:0] x, input logic [62:0] ez,
                           input logic [6:0] eh, input logic clr_same);
        int lat1;
        int lat4;
        chk({name, " in_ready"}, 96'({b1.in_ready, b4.in_ready}), 96'(2'b11));
        in_valid = 1'b1; in_x = x; cfg_clr = clr_same;
        step();
        in_valid = 1'b0; cfg_clr = 1'b0; in_x = ~x;
        lat1 = 0; lat4 = 0;
        for (int c = 1; c <= 200 && (lat1 == 0 || lat4 == 0); c++) begin
            step();
            if (b1.out_valid && lat1 == 0) lat1 = c;
            if (b4.out_valid && lat4 == 0) lat4 = c;
        end
        chk({name, " lat1"}, 96'(lat1), 96'(64));
        chk({name, " lat4"}, 96'(lat4), 96'(16));
        chk({name, " z1"}, 96'(b1.out_z), 96'(ez));
        chk({name, " hits1"}, 96'(b1.out_hits), 96'(eh));
        chk({name, " z4"}, 96'(b4.out_z), 96'(ez));
        chk({name, " hits4"}, 96'(b4.out_hits), 96'(eh));
        rdy1 = 1'b1; rdy4 = 1'b1;
        step();
        rdy1 = 1'b0; rdy4 = 1'b0;
        chk({name, " consumed"}, 96'({b1.out_valid, b4.out_valid, b1.in_ready, b4.in_ready}),
            96'(4'b0011));
    endtask

    initial begin
        tbl[0] = '{0, 30'h2AAAAAAA, 63'h0, 7'd0};
        tbl[1] = '{1, 30'h1, 63'h1, 7'd1};
        tbl[2] = '{0, 30'h3, 63'h0, 7'd0};
        tbl[3] = '{0, 30'h3FFFFFFD, 63'h1, 7'd1};
        tbl[4] = '{2, 30'h1, B62 | 63'h2, 7'd2};
        tbl[5] = '{0, 30'h0, B62, 7'd1};

        // Reset state
        step(); step();
        chk("reset outputs", 96'({b1.out_valid, b1.out_hits, b1.out_z}), 96'(0));
        chk("reset ready", 96'({b1.cfg_ready, b1.in_ready, b4.cfg_ready, b4.in_ready}), 96'(4'hF));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            case (tbl[i].setup)
                1: cfg_write(6'd5, 30'h3, 30'h1, 63'h1, 1'b0);
                2: begin
                    cfg_clr = 1'b1; step(); cfg_clr = 1'b0;
                    cfg_write(6'd0, 30'h0, 30'h0, B62, 1'b0);
                    cfg_write(6'd63, 30'h1, 30'h1, 63'h2, 1'b0);
                end
                default: ;
            endcase
            run_vec($sformatf("vec%0d", i), tbl[i].x, tbl[i].z, tbl[i].h, 1'b0);
        end

        // Result held in DONE while the consumer stalls; config writes are ignored
        in_valid = 1'b1; in_x = 30'h1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 100 && !b1.out_valid; c++) step();
        chk("hold reached", 96'(b1.out_valid), 96'(1));
        for (int c = 0; c < 10; c++) begin
            cfg_we = 1'b1; cfg_addr = 6'd0; cfg_care = 30'h3FFFFFFF; cfg_val = 30'h15;
            cfg_omask = 63'h20;
            step();
            chk($sformatf("hold result c%0d", c), 96'({b1.out_valid, b1.out_hits, b1.out_z}),
                {25'd0, 1'b1, 7'd2, B62 | 63'h2});
            chk($sformatf("hold ready c%0d", c), 96'({b1.in_ready, b1.cfg_ready}), 96'(0));
        end
        cfg_we = 1'b0; rdy1 = 1'b1; rdy4 = 1'b1;
        step();
        rdy1 = 1'b0; rdy4 = 1'b0;
        run_vec("after_hold", 30'h1, B62 | 63'h2, 7'd2, 1'b0);

        // Clear arriving together with an accepted vector wins over the always-matching terms
        cfg_write(6'd10, 30'h0, 30'h0, 63'h8, 1'b0);
        run_vec("clr_same_cycle", 30'h123, 63'h0, 7'd0, 1'b1);
        cfg_write(6'd7, 30'h0, 30'h0, 63'h10, 1'b1);
        run_vec("clr_and_we", 30'h0, 63'h10, 7'd1, 1'b0);

        // Reset in the middle of evaluation drops the result and the table
        cfg_write(6'd0, 30'h0, 30'h0, B62, 1'b0);
        in_valid = 1'b1; in_x = 30'h0;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) step();
        rst_n = 1'b0;
        #2;
        chk("midreset valid", 96'({b1.out_valid, b4.out_valid}), 96'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("post reset", 96'({b1.in_ready, b1.cfg_ready, b1.out_valid, b1.out_hits}),
            96'({1'b1, 1'b1, 1'b0, 7'd0}));
        run_vec("after_reset", 30'h0, 63'h0, 7'd0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
